// File: rtl/vic_irq_front.sv
// vic_irq_front: interrupt front end for the vectored interrupt controller.
// Captures external lines, tracks pending / in-service state and presents one
// registered request plus source index to vic_ctrl.
// Build option: define VIC_IRQ_SYNC_EN to add a two-flop synchronizer on every
// i_ext bit (asynchronous pins). Without it i_ext must be synchronous to clk.
module vic_irq_front #(
  parameter int N_SRC = 31,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] i_ext,
  input  logic [N_SRC-1:0] i_enable,
  input  logic [N_SRC-1:0] i_edge_sel,
  output logic             o_irq_req,
  output logic [IDX_W-1:0] o_irq_idx,
  input  logic             i_irq_ack,
  input  logic             i_reti,
  output logic [N_SRC-1:0] o_pending,
  output logic [N_SRC-1:0] o_inservice
);

  logic [N_SRC-1:0] sync;
  logic [N_SRC-1:0] prev;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] inservice;
  logic [N_SRC-1:0] edge_det;
  logic [N_SRC-1:0] ack_hot;
  logic [N_SRC-1:0] ins_low;
  logic [N_SRC-1:0] pend_nxt;
  logic [N_SRC-1:0] ins_nxt;
  logic [N_SRC-1:0] elig;
  logic             ack_ok;
  logic             enc_found;
  logic [IDX_W-1:0] enc_idx;

`ifdef VIC_IRQ_SYNC_EN
  logic [N_SRC-1:0] s1;
  logic [N_SRC-1:0] s2;

  // Two-flop synchronizer for asynchronous interrupt pins
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= i_ext;
      s2 <= s1;
    end
  end

  assign sync = s2;
`else
  assign sync = i_ext;
`endif

  assign edge_det = sync & ~prev;

  // An ack only counts while a request is actually being presented
  assign ack_ok  = i_irq_ack & o_irq_req;
  assign ack_hot = ack_ok ? (N_SRC'(1) << o_irq_idx) : '0;

  // One-hot of the lowest-index (highest-priority) in-service source
  assign ins_low = inservice & (~inservice + N_SRC'(1));

  // Pending/in-service next state: edge sticky until acked (new edge wins),
  // level follows input; reti clears first, then ack sets
  always_comb begin
    pend_nxt = (i_edge_sel & (edge_det | (pending & ~ack_hot))) | (~i_edge_sel & sync);
    ins_nxt  = (i_reti ? (inservice & ~ins_low) : inservice) | ack_hot;
  end

  // ins_low - 1 masks every index below the active in-service level;
  // with nothing in service it wraps to all-ones so every source qualifies
  assign elig = pending & i_enable & (ins_low - N_SRC'(1));

  // Fixed priority encoder: lowest eligible index wins
  always_comb begin
    enc_found = 1'b0;
    enc_idx   = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (elig[i] && !enc_found) begin
        enc_found = 1'b1;
        enc_idx   = IDX_W'(i);
      end
    end
  end

  // Registered state and request; ack forces the request low for a cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev      <= '0;
      pending   <= '0;
      inservice <= '0;
      o_irq_req <= 1'b0;
      o_irq_idx <= '0;
    end else begin
      prev      <= sync;
      pending   <= pend_nxt;
      inservice <= ins_nxt;
      if (i_irq_ack) begin
        o_irq_req <= 1'b0;
      end else begin
        o_irq_req <= enc_found;
        o_irq_idx <= enc_idx;
      end
    end
  end

  assign o_pending   = pending;
  assign o_inservice = inservice;

endmodule
